// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on the operand and result
// channels. It executes AND/XOR/OR/ADD/SUB/SHL/SHR in one cycle and keeps one
// operation in flight at a time.
// Build option: define ALU_SEQ_MUL_EN to include the multi-cycle shift-add
// multiplier. When the macro is undefined, opcode 101 completes in one cycle
// with a zero result and err=1.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_BUSY = 2'b01,
    DONE     = 2'b10
  } state_t;

  state_t state_r;

  // Single-cycle datapath results
  logic [WIDTH-1:0] res_s;
  logic             z_s;
  logic             c_s;
  logic             v_s;
  logic             err_s;
  logic             is_mul_s;
  logic [SHW-1:0]   amt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   shr_s;

  // Single-cycle ALU: the extra bit of each WIDTH+1 result carries
  // the carry, borrow or shifted-out bit.
  always_comb begin
    amt_s  = b[SHW-1:0];
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    // SHL: the bit shifted out last lands in position WIDTH
    shl_s  = {1'b0, a} << amt_s;
    // SHR: the bit shifted out last lands in position 0
    shr_s  = {a, 1'b0} >> amt_s;
    res_s  = {WIDTH{1'b0}};
    c_s    = 1'b0;
    v_s    = 1'b0;
    err_s  = 1'b0;
    case (opcode)
      OP_AND: res_s = a & b;
      OP_XOR: res_s = a ^ b;
      OP_OR:  res_s = a | b;
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        // Same-sign operands whose sum has the other sign
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        // Different-sign operands whose difference has b's sign
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        res_s = shl_s[WIDTH-1:0];
        c_s   = shl_s[WIDTH];
      end
      OP_SHR: begin
        res_s = shr_s[WIDTH:1];
        c_s   = shr_s[0];
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        err_s = 1'b0;
`else
        err_s = 1'b1;
`endif
      end
      default: begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        err_s = 1'b0;
      end
    endcase
    // An unsupported op reports all flags clear, including zero
    z_s = ~err_s & (res_s == {WIDTH{1'b0}});
  end

  // Routes an accepted MUL to the multiplier only when it is built in
  always_comb begin
`ifdef ALU_SEQ_MUL_EN
    is_mul_s = (opcode == OP_MUL);
`else
    is_mul_s = 1'b0;
`endif
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;

  // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Multiplier registers: load on MUL accept, step once per MUL_BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == IDLE && in_valid && in_ready && is_mul_s) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= b;
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == MUL_BUSY) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
    end else begin
      mcand_r  <= mcand_r;
      acc_r    <= acc_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= {WIDTH{1'b0}};
      out_hi    <= {WIDTH{1'b0}};
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (is_mul_s) begin
              state_r <= MUL_BUSY;
            end else begin
              out       <= res_s;
              out_hi    <= {WIDTH{1'b0}};
              flag_z    <= z_s;
              flag_c    <= c_s;
              flag_v    <= v_s;
              err       <= err_s;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL_BUSY: begin
          // The last step's sum is registered directly so the result
          // appears WIDTH+1 cycles after the accept
          if (cnt_r == CW'(WIDTH - 1)) begin
            out       <= acc_next_s[WIDTH-1:0];
            out_hi    <= acc_next_s[2*WIDTH-1:WIDTH];
            flag_z    <= (acc_next_s == {(2*WIDTH){1'b0}});
            flag_c    <= |acc_next_s[2*WIDTH-1:WIDTH];
            flag_v    <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
`endif
        DONE: begin
          // Hold the result until the consumer takes it; accepts reopen next cycle
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=8) against an arithmetic
// reference model. It follows ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int SHB = $clog2(W);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;
  logic         err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
    logic         err;
    int           lat;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint md, ua, ub, sa, sb, sr, full;
    int     amt;
    md  = longint'(1) << W;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = (ua >= md / 2) ? ua - md : ua;
    sb  = (ub >= md / 2) ? ub - md : ub;
    amt = int'(ub % (longint'(1) << SHB));
    e.out = '0; e.hi = '0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      3'd0: e.out = av & bv;
      3'd1: e.out = av ^ bv;
      3'd2: e.out = av | bv;
      3'd3: begin
        full  = ua + ub;
        e.out = W'(full % md);
        e.c   = (full >= md);
        sr    = sa + sb;
        e.v   = (sr >= md / 2) || (sr < -(md / 2));
      end
      3'd4: begin
        full  = ua - ub;
        e.out = W'((full + md) % md);
        e.c   = (ua < ub);
        sr    = sa - sb;
        e.v   = (sr >= md / 2) || (sr < -(md / 2));
      end
      3'd5: begin
`ifdef ALU_SEQ_MUL_EN
        full  = ua * ub;
        e.out = W'(full % md);
        e.hi  = W'(full / md);
        e.z   = (full == 0);
        e.c   = (full / md) != 0;
        e.lat = W + 1;
`else
        e.err = 1'b1;
`endif
        return e;
      end
      3'd6: begin
        e.out = W'((ua * (longint'(1) << amt)) % md);
        e.c   = (amt > 0) && (((ua >> (W - amt)) & 1) == 1);
      end
      default: begin
        e.out = W'(ua >> amt);
        e.c   = (amt > 0) && (((ua >> (amt - 1)) & 1) == 1);
      end
    endcase
    e.z = (e.out == '0);
    return e;
  endfunction

  // One full transaction: accept, latency, result, hold under stall, drain
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input int stall);
    exp_t e;
    int   n;
    e = model(op, av, bv);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready", in_ready, 1);
    in_valid  = 1'b1;
    opcode    = op;
    a         = av;
    b         = bv;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    opcode   = 3'($urandom);
    chk("accept_rdy", in_ready, 0);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, e.lat);
    chk("out", out, e.out);
    chk("out_hi", out_hi, e.hi);
    chk("flag_z", flag_z, e.z);
    chk("flag_c", flag_c, e.c);
    chk("flag_v", flag_v, e.v);
    chk("err", err, e.err);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_out", out, e.out);
      chk("hold_c", flag_c, e.c);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 0);
    chk("drain_rdy", in_ready, 1);
    chk("drain_err", err, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 3'b001;
    a         = 8'h01;
    b         = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_hi", out_hi, 0);
    chk("rst_flags", {flag_z, flag_c, flag_v, err}, 0);
    rst = 1'b0;

    run_op(3'b001, 8'h1F, 8'h11, 0);
    run_op(3'b011, 8'hFF, 8'h01, 0);
    run_op(3'b011, 8'h7F, 8'h01, 0);
    run_op(3'b100, 8'h80, 8'h01, 1);
    run_op(3'b100, 8'h01, 8'h02, 0);
    run_op(3'b101, 8'h1F, 8'h11, 0);
    run_op(3'b110, 8'h81, 8'h01, 3);
    run_op(3'b111, 8'h81, 8'h00, 0);
    run_op(3'b111, 8'h81, 8'h03, 0);

    // Reset during the fourth MUL_BUSY cycle discards the operation
    in_valid  = 1'b1;
    opcode    = 3'b101;
    a         = 8'hE7;
    b         = 8'h5B;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_out", {out_hi, out}, 0);
    chk("midrst_flags", {flag_z, flag_c, flag_v, err}, 0);
    run_op(3'b001, 8'h01, 8'h01, 0);

    for (int i = 0; i < 200; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 2-bit-opcode ALU (`main_design`).
- Generalised to WIDTH-bit operands and a 3-bit opcode; adds arithmetic, status flags and a multi-cycle shift-add multiply.
- Uses valid/ready handshakes on the operand and result channels.
- Sits between the register file and writeback of the course datapath; one operation in flight at a time.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- SHW, $clog2(WIDTH): shift-amount bits taken from b[SHW-1:0] (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; synchronous, active-high.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation.
- opcode  input  3  000 AND, 001 XOR, 010 OR, 011 ADD, 100 SUB, 101 MUL, 110 SHL, 111 SHR (logical).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result (MUL: low half).
- out_hi  output  WIDTH  MUL high half; 0 for all other ops.
- flag_z  output  1  out == 0 (MUL: full 2*WIDTH product == 0).
- flag_c  output  1  ADD carry-out; SUB borrow (a < b unsigned); MUL: out_hi != 0; last bit shifted out for SHL/SHR; 0 for logic ops.
- flag_v  output  1  signed overflow for ADD/SUB; 0 otherwise.
- err  output  1  unsupported opcode (see Optional Feature).

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out, out_hi, flags and err all 0. rst wins over every other input in the same cycle.
- FSM states: IDLE, MUL_BUSY, DONE.
  - IDLE, in_valid && in_ready, opcode != MUL: compute combinationally, register the result, go to DONE. out_valid=1 on the next cycle (latency 1).
  - IDLE, MUL accepted: latch a and b, clear the accumulator and counter, go to MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle for exactly WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1. Outputs hold stable until out_valid && out_ready, then go to IDLE.
- in_ready=1 only in IDLE. No accept in the same cycle the result drains; the next accept is possible one cycle later. Throughput: single-cycle op every 2 cycles with out_ready held high.
- Inputs a, b and opcode are don't-care when not accepting; changes during MUL_BUSY do not affect the result.
- Arithmetic:
  - ADD/SUB computed at WIDTH+1 bits for carry/borrow.
  - flag_v set when operand signs satisfy the two's-complement overflow rule.
  - SHL/SHR: shift amount b[SHW-1:0]; amount 0 gives out=a, flag_c=0.
- out_valid is never deasserted without out_ready (AXI-style hold).
- Reset mid-MUL discards the operation; no partial result is ever presented.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL behaves as above; err is constantly 0.
- Undefined:
  - MUL_BUSY and the multiplier datapath are not synthesised.
  - opcode 101 is accepted as a single-cycle op: out=0, out_hi=0, flags 0, err=1 for that result only.
  - err clears when the result drains.

Test Plan:
- XOR legacy check, WIDTH=8: a=0x1F, b=0x11, op=001, out_ready=1 -> next cycle out_valid=1, out=0x0E, z=0, c=0, v=0; next accept one cycle after drain.
- ADD wrap: a=0xFF, b=0x01 -> out=0x00, z=1, c=1, v=0. Signed overflow: a=0x7F, b=0x01 -> out=0x80, v=1, c=0.
- SUB: a=0x80, b=0x01 -> out=0x7F, v=1, c=0. Borrow case: a=0x01, b=0x02 -> out=0xFF, c=1.
- MUL (macro defined): a=0x1F, b=0x11 -> in_ready=0 for the op; out_valid exactly 9 cycles after accept; out=0x0F, out_hi=0x02, c=1. Macro undefined: out=0, err=1 after 1 cycle.
- Backpressure: SHL a=0x81, b=0x01, out_ready=0 for 3 cycles -> out=0x02, c=1 held stable with out_valid=1 and in_ready=0 throughout; drains on the cycle out_ready=1.
- Reset mid-MUL: assert rst on the 4th MUL_BUSY cycle -> next cycle out_valid=0, in_ready=1, all outputs 0; a following XOR 0x01^0x01 yields out=0x00, z=1.
